// File: rtl/hazard_scoreboard.sv
// Forwarding, load-use and long-latency busy scoreboard hazard unit beside the ID stage.
// Optional stall-cycle counter is built when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned RSV_REG  = 30,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned CW       = $clog2(MAX_OUT + 1)
) (
    input  logic            clk,
    input  logic            rst_sync,
    input  logic            id_valid,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_is_lop,
    input  logic [AW-1:0]   rd_ex,
    input  logic [AW-1:0]   rd_mem,
    input  logic [AW-1:0]   rd_wb,
    input  logic            regwrite_ex,
    input  logic            regwrite_mem,
    input  logic            regwrite_wb,
    input  logic            kill_ex,
    input  logic            kill_mem,
    input  logic            kill_wb,
    input  logic            memread_ex,
    input  logic            lop_issue,
    input  logic [AW-1:0]   lop_rd,
    input  logic            lop_done,
    input  logic [AW-1:0]   lop_done_rd,
    output logic [2:0]      fwd_a,
    output logic [2:0]      fwd_b,
    output logic            stall,
    output logic [NREG-1:0] busy_vec,
    output logic [CW-1:0]   outstanding,
    output logic            sb_err,
    output logic [31:0]     stall_cnt
);

    function automatic logic exempt(input logic [AW-1:0] r);
        return (r == AW'(ZERO_REG)) || (r == AW'(RSV_REG));
    endfunction

    logic [NREG-1:0]      busy_q, busy_d, busy_eff;
    logic [CW-1:0]        out_q, out_d, out_eff;
    logic                 err_q, err_d;
    logic [1:0][AW-1:0]   src;
    logic [1:0]           use_src;
    logic [1:0][2:0]      fwd;
    logic [1:0]           src_hz;
    logic                 waw, st;
    logic                 done_v, issue_v, done_hit, same_reg, full_drop;

    // During reset the combinational view sees an empty scoreboard.
    assign busy_eff = rst_sync ? '0 : busy_q;
    assign out_eff  = rst_sync ? '0 : out_q;

    assign src     = {rt, rs};
    assign use_src = {use_rt, use_rs};

    always_comb begin
        fwd    = '0;
        src_hz = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (!exempt(src[i])) begin
                if (regwrite_ex && !kill_ex && rd_ex == src[i]) begin
                    fwd[i] = 3'b001;
                end else if (regwrite_mem && !kill_mem && rd_mem == src[i]) begin
                    fwd[i] = 3'b010;
                end else if (regwrite_wb && !kill_wb && rd_wb == src[i]) begin
                    fwd[i] = 3'b011;
                end else if (lop_done && lop_done_rd == src[i]) begin
                    fwd[i] = 3'b100;
                end
                if (use_src[i]) begin
                    src_hz[i] = (memread_ex && !kill_ex && rd_ex == src[i])
                              || (busy_eff[src[i]] && !(lop_done && lop_done_rd == src[i]))
                              || (lop_issue && lop_rd == src[i]);
                end
            end
        end
    end

    // WAW has no completion bypass; it releases one cycle after done.
    assign waw = id_wr && !exempt(id_rd)
               && (busy_eff[id_rd] || (lop_issue && lop_rd == id_rd));
    assign st  = id_is_lop
               && (({1'b0, out_eff} + {{CW{1'b0}}, lop_issue}) >= (CW+1)'(MAX_OUT));

    assign fwd_a = fwd[0];
    assign fwd_b = fwd[1];
    assign stall = id_valid && (|src_hz || waw || st);

    always_comb begin
        done_v    = lop_done && !exempt(lop_done_rd);
        issue_v   = lop_issue && !exempt(lop_rd);
        done_hit  = done_v && busy_q[lop_done_rd];
        same_reg  = done_hit && issue_v && (lop_done_rd == lop_rd);
        full_drop = issue_v && (out_q == CW'(MAX_OUT)) && !done_hit;
        busy_d    = busy_q;
        if (done_hit) begin
            busy_d[lop_done_rd] = 1'b0;
        end
        if (issue_v && !full_drop) begin
            busy_d[lop_rd] = 1'b1;
        end
        err_d = err_q
              | (done_v && !busy_q[lop_done_rd])
              | (issue_v && busy_q[lop_rd] && !same_reg)
              | full_drop;
        out_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            out_d = out_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            busy_q <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            out_q  <= out_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec    = busy_q;
    assign outstanding = out_q;
    assign sb_err      = err_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cnt_q <= '0;
        end else if (stall && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        id_valid, use_rs, use_rt, id_wr, id_is_lop;
    logic [4:0]  rs, rt, id_rd, rd_ex, rd_mem, rd_wb, lop_rd, lop_done_rd;
    logic        regwrite_ex, regwrite_mem, regwrite_wb;
    logic        kill_ex, kill_mem, kill_wb, memread_ex;
    logic        lop_issue, lop_done;
    logic [2:0]  fwd_a, fwd_b;
    logic        stall, sb_err;
    logic [31:0] busy_vec, stall_cnt, exp_cnt;
    logic [2:0]  outstanding;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_sync(rst_sync), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_lop(id_is_lop), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .kill_ex(kill_ex), .kill_mem(kill_mem), .kill_wb(kill_wb), .memread_ex(memread_ex),
        .lop_issue(lop_issue), .lop_rd(lop_rd), .lop_done(lop_done),
        .lop_done_rd(lop_done_rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .busy_vec(busy_vec), .outstanding(outstanding), .sb_err(sb_err),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        id_valid = 0; use_rs = 0; use_rt = 0; id_wr = 0; id_is_lop = 0;
        rs = 0; rt = 0; id_rd = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
        regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
        kill_ex = 0; kill_mem = 0; kill_wb = 0; memread_ex = 0;
        lop_issue = 0; lop_rd = 0; lop_done = 0; lop_done_rd = 0;
    endtask

    initial begin
        clear();
        rst_sync = 1;
        tick();
        tick();
        chk("rst_busy", busy_vec, 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_err", 32'(sb_err), 0);
        chk("rst_cnt", stall_cnt, 0);
        rst_sync = 0;
        tick();

        // forwarding priority
        id_valid = 1; use_rs = 1; rs = 5;
        rd_ex = 5; rd_mem = 5; rd_wb = 5;
        regwrite_ex = 1; regwrite_mem = 1; regwrite_wb = 1;
        #1 chk("fwd_ex", 32'(fwd_a), 1);
        chk("fwd_nostall", 32'(stall), 0);
        kill_ex = 1;
        #1 chk("fwd_mem", 32'(fwd_a), 2);
        kill_mem = 1;
        #1 chk("fwd_wb", 32'(fwd_a), 3);
        kill_ex = 0; kill_mem = 0;
        rs = 30; rd_ex = 30; rd_mem = 30; rd_wb = 5; rt = 5;
        #1 chk("fwd_rsv", 32'(fwd_a), 0);
        chk("fwd_b_wb", 32'(fwd_b), 3);
        clear();

        // load-use
        id_valid = 1; memread_ex = 1; regwrite_ex = 1; rd_ex = 7; rt = 7; use_rt = 1;
        #1 chk("lu_stall", 32'(stall), 1);
        chk("lu_fwd_b", 32'(fwd_b), 1);
        use_rt = 0;
        #1 chk("lu_unused", 32'(stall), 0);
        use_rt = 1; kill_ex = 1;
        #1 chk("lu_killed", 32'(stall), 0);
        kill_ex = 0; id_valid = 0;
        #1 chk("lu_novalid", 32'(stall), 0);
        clear();
        tick();

        // long-latency RAW with completion bypass
        lop_issue = 1; lop_rd = 9; id_valid = 1; rs = 9; use_rs = 1;
        #1 chk("raw_issue_stall", 32'(stall), 1);
        tick();
        lop_issue = 0;
        #1 chk("raw_busy", busy_vec, 32'h200);
        chk("raw_out", 32'(outstanding), 1);
        chk("raw_stall", 32'(stall), 1);
        tick();
        chk("raw_stall_hold", 32'(stall), 1);
        lop_done = 1; lop_done_rd = 9;
        #1 chk("raw_release", 32'(stall), 0);
        chk("raw_fwd_bus", 32'(fwd_a), 4);
        tick();
        lop_done = 0;
        #1 chk("raw_clear", busy_vec, 0);
        chk("raw_out0", 32'(outstanding), 0);
        chk("raw_err", 32'(sb_err), 0);
        clear();

        // fill to MAX_OUT, structural and WAW
        lop_issue = 1;
        lop_rd = 1; tick();
        lop_rd = 2; tick();
        lop_rd = 3; id_valid = 1; id_is_lop = 1;
        #1 chk("st_below", 32'(stall), 0);
        tick();
        lop_rd = 4;
        #1 chk("st_issue_full", 32'(stall), 1);
        tick();
        lop_issue = 0;
        #1 chk("full_out", 32'(outstanding), 4);
        chk("full_busy", busy_vec, 32'h1E);
        chk("st_full", 32'(stall), 1);
        id_is_lop = 0; id_wr = 1; id_rd = 2; lop_issue = 1; lop_rd = 5;
        #1 chk("waw_stall", 32'(stall), 1);
        tick();
        lop_issue = 0;
        #1 chk("drop_err", 32'(sb_err), 1);
        chk("drop_busy", busy_vec, 32'h1E);
        chk("drop_out", 32'(outstanding), 4);
        lop_done = 1; lop_done_rd = 2;
        #1 chk("waw_done_cycle", 32'(stall), 1);
        tick();
        lop_done = 0;
        #1 chk("waw_release", 32'(stall), 0);
        chk("waw_busy", busy_vec, 32'h1A);
        chk("waw_out", 32'(outstanding), 3);
        clear();

        // reset with outstanding ops; done during reset ignored
        rst_sync = 1; lop_done = 1; lop_done_rd = 1; id_valid = 1; use_rs = 1; rs = 3;
        #1 chk("rst_comb_empty", 32'(stall), 0);
        tick();
        chk("flush_busy", busy_vec, 0);
        chk("flush_out", 32'(outstanding), 0);
        chk("flush_err", 32'(sb_err), 0);
        rst_sync = 0;
        clear();
        tick();
        lop_done = 1; lop_done_rd = 3;
        tick();
        lop_done = 0;
        chk("stray_done_err", 32'(sb_err), 1);

        // simultaneous issue/done on a busy register
        rst_sync = 1; tick(); rst_sync = 0;
        lop_issue = 1; lop_rd = 6; tick();
        chk("r6_busy", busy_vec, 32'h40);
        lop_done = 1; lop_done_rd = 6; tick();
        lop_done = 0;
        chk("same_busy", busy_vec, 32'h40);
        chk("same_out", 32'(outstanding), 1);
        chk("same_err", 32'(sb_err), 0);
        tick();
        lop_issue = 0;
        chk("reissue_err", 32'(sb_err), 1);

        // exempt registers ignored
        rst_sync = 1; tick(); rst_sync = 0;
        lop_issue = 1; lop_rd = 0; lop_done = 1; lop_done_rd = 30; tick();
        clear();
        chk("exempt_busy", busy_vec, 0);
        chk("exempt_err", 32'(sb_err), 0);

        // stall counter
        rst_sync = 1; tick(); rst_sync = 0; tick();
        chk("cnt_rst", stall_cnt, 0);
        id_valid = 1; memread_ex = 1; rd_ex = 7; rt = 7; use_rt = 1;
        repeat (10) tick();
        clear();
`ifdef HAZARD_STALL_CNT_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        tick();
        chk("cnt_10", stall_cnt, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline, successor to the fixed 32-register forwarding/stall unit. It keeps EX/MEM/WB forwarding and load-use detection. It adds a per-register busy scoreboard for long-latency operations (divider, variable-latency memory) that complete out of band, with RAW/WAW/structural stalls and a completion-bus bypass. It sits beside the ID stage and drives the ID/EX forwarding muxes and the IF/ID stall.

## Interface
- NREG, 32, architectural register count
- AW, 5, register index width; NREG == 2**AW
- ZERO_REG, 0, hard-wired zero register; never forwarded, never busy, never stalls
- RSV_REG, 30, reserved register; same exemptions as ZERO_REG
- MAX_OUT, 4, maximum outstanding long-latency ops (1..NREG-2)
- CW, $clog2(MAX_OUT+1), width of outstanding count
- clk  in  1  clock; all state updates on posedge
- rst_sync  in  1  synchronous active-high reset
- id_valid  in  1  valid instruction in ID; all stalls gated by it
- rs, rt  in  AW  ID source indices
- use_rs, use_rt  in  1  source actually read
- id_wr, id_rd  in  1, AW  ID instruction writes id_rd
- id_is_lop  in  1  ID instruction is long-latency
- rd_ex, rd_mem, rd_wb  in  AW  destination per stage
- regwrite_ex, regwrite_mem, regwrite_wb  in  1  stage writes (0 for a lop in EX)
- kill_ex, kill_mem, kill_wb  in  1  predicated off (1 = killed)
- memread_ex  in  1  load in EX
- lop_issue, lop_rd  in  1, AW  non-killed lop leaving EX this cycle
- lop_done, lop_done_rd  in  1, AW  lop result on completion bus this cycle (written to RF at this edge)
- fwd_a, fwd_b  out  3  000 RF, 001 EX, 010 MEM, 011 WB, 100 completion bus
- stall  out  1  hold IF/ID, bubble into EX
- busy_vec  out  NREG  scoreboard bits, registered
- outstanding  out  CW  popcount of busy_vec, registered
- sb_err  out  1  sticky protocol error, cleared only by reset
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Exempt(r): r == ZERO_REG or r == RSV_REG.
- Forward selection is per source, first match wins.
  - EX: regwrite_ex && !kill_ex && rd_ex == src && !exempt.
  - MEM: same terms on the MEM-stage signals.
  - WB: same terms on the WB-stage signals.
  - Completion bus: lop_done && lop_done_rd == src && !exempt.
  - Otherwise RF.
- stall = id_valid && (LU || RAW || WAW || ST). Each term is evaluated only for sources with use_x = 1 and only for non-exempt registers:
  - LU: memread_ex && !kill_ex && rd_ex == src.
  - RAW: src busy and not (lop_done && lop_done_rd == src); or lop_issue && lop_rd == src.
  - WAW: id_wr && (busy[id_rd] || (lop_issue && lop_rd == id_rd)). No done bypass, so this is conservative by one cycle.
  - ST: id_is_lop && (outstanding + lop_issue) >= MAX_OUT. Done is ignored.
- Scoreboard update per edge:
  - Done clears busy[lop_done_rd].
  - Issue sets busy[lop_rd].
  - Issue and done on the same register in the same cycle: the bit stays set.
  - Issue or done on an exempt register is ignored.
- outstanding always equals popcount(busy_vec) after the edge.
- sb_err sets on any of:
  - done to a non-busy register;
  - issue to an already-busy register (done of that register in the same cycle excepted);
  - issue while outstanding == MAX_OUT and no done in the same cycle. The issue is dropped.

## Timing
- fwd_a, fwd_b and stall are combinational from inputs and registered state; no added latency.
- Scoreboard and outstanding changes are visible the cycle after the issue or done edge.
- RAW on a busy register releases in the done cycle, via fwd = 100.
- WAW releases the cycle after done.
- Reset: busy_vec = 0, outstanding = 0, sb_err = 0, stall_cnt = 0.
- Reset mid-operation flushes all pending lops. lop_done during a reset cycle is ignored. A stray done after reset sets sb_err, so long-latency units must share rst_sync.
- While rst_sync = 1, the combinational outputs still follow inputs with the scoreboard treated as empty.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt increments on each edge where stall = 1 and rst_sync = 0, and saturates at 32'hFFFF_FFFF.
- HAZARD_STALL_CNT_EN undefined: the port remains and is tied to 0, and no counter flops are built.

## Test plan
- Forward priority: rd_ex = rd_mem = rd_wb = 5, all writing, rs = 5 -> fwd_a = 001. Set kill_ex = 1 -> 010. rs = 30 -> 000.
- Load-use: memread_ex = 1, rd_ex = 7, rt = 7, use_rt = 1 -> stall = 1. use_rt = 0 -> stall = 0.
- Lop RAW: issue lop_rd = 9 -> busy_vec[9] = 1, outstanding = 1. ID reads r9 -> stall held. lop_done_rd = 9 -> stall = 0, fwd_a = 100 that cycle. Next cycle busy_vec[9] = 0.
- WAW and structural with MAX_OUT = 4:
  - Issue r1..r4 -> outstanding = 4; ID lop -> stall = 1.
  - ID write to r2 -> stall until the cycle after done r2.
  - Issue r5 while full -> sb_err = 1, busy_vec[5] = 0.
- Simultaneous issue and done on r6 with r6 busy -> busy_vec[6] = 1, outstanding unchanged, sb_err = 0.
- Reset with 3 outstanding -> busy_vec = 0, outstanding = 0. A later done r3 -> sb_err = 1. With the macro, 10 stall cycles -> stall_cnt = 10.
